// File: rtl/fpnew_round_arbiter.sv
// Shared rounding stage: round-robin pick of one pre-rounded op per cycle,
// rounded through a two-stage valid/ready pipeline and tagged with its source.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i
//   req_*_i / req_ready_o : per-requester flat vectors (requester i at slice i)
//   out_*_o / out_ready_i : rounded result with sign, zero, inexact, illegal,
//                           source index and echoed tag
module fpnew_round_arbiter #(
  parameter int NumReq   = 4,
  parameter int AbsWidth = 31,
  parameter int TagWidth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*AbsWidth-1:0]   req_abs_i,
  input  logic [NumReq-1:0]            req_sign_i,
  input  logic [NumReq*2-1:0]          req_rs_i,
  input  logic [NumReq*3-1:0]          req_rm_i,
  input  logic [NumReq-1:0]            req_effsub_i,
  input  logic [NumReq*TagWidth-1:0]   req_tag_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [AbsWidth-1:0]          out_abs_o,
  output logic                         out_sign_o,
  output logic                         out_zero_o,
  output logic                         out_inexact_o,
  output logic                         out_illegal_o,
  output logic [$clog2(NumReq)-1:0]    out_src_o,
  output logic [TagWidth-1:0]          out_tag_o
);

  localparam int SrcW = $clog2(NumReq);
  localparam logic [SrcW:0] NumReqW = (SrcW+1)'(NumReq);
  localparam logic [SrcW-1:0] LastIdx = SrcW'(NumReq-1);

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;
  localparam logic [2:0] ROD = 3'd5;

  logic [SrcW-1:0]     rr_q;
  logic                s1_valid;
  logic                s2_valid;
  logic                s1_free;
  logic                s2_free;
  logic                accept_ok;
  logic                accept;
  logic                s2_load;

  logic                grant_found;
  logic [SrcW-1:0]     grant_idx;
  logic [NumReq-1:0]   grant_oh;

  logic [AbsWidth-1:0] sel_abs;
  logic                sel_sign;
  logic [1:0]          sel_rs;
  logic [2:0]          sel_rm;
  logic                sel_effsub;
  logic [TagWidth-1:0] sel_tag;

  logic [AbsWidth-1:0] s1_abs;
  logic                s1_sign;
  logic [1:0]          s1_rs;
  logic [2:0]          s1_rm;
  logic                s1_effsub;
  logic [TagWidth-1:0] s1_tag;
  logic [SrcW-1:0]     s1_src;

  logic                round_up;
  logic                illegal;
  logic                exact_zero;
  logic                sign_res;
  logic [AbsWidth-1:0] abs_rnd;

  assign s2_free   = ~s2_valid | out_ready_i;
  assign s1_free   = ~s1_valid | s2_free;
  // Reset and flush both suppress acceptance in the same cycle.
  assign accept_ok = s1_free & ~flush_i & ~rst_i;
  assign accept    = grant_found & accept_ok;
  assign s2_load   = s1_valid & s2_free & ~flush_i;

  // Scan rr_q, rr_q+1, ... modulo NumReq; first valid wins.
  always_comb begin
    logic [SrcW:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = {1'b0, rr_q} + (SrcW+1)'(k);
      if (cand >= NumReqW) cand = cand - NumReqW;
      if (!grant_found && req_valid_i[cand[SrcW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SrcW-1:0];
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_found) grant_oh[grant_idx] = 1'b1;
  end

  assign req_ready_o = grant_oh & {NumReq{accept_ok}};

  always_comb begin
    sel_abs    = '0;
    sel_sign   = 1'b0;
    sel_rs     = '0;
    sel_rm     = '0;
    sel_effsub = 1'b0;
    sel_tag    = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant_oh[i]) begin
        sel_abs    = req_abs_i[i*AbsWidth +: AbsWidth];
        sel_sign   = req_sign_i[i];
        sel_rs     = req_rs_i[i*2 +: 2];
        sel_rm     = req_rm_i[i*3 +: 3];
        sel_effsub = req_effsub_i[i];
        sel_tag    = req_tag_i[i*TagWidth +: TagWidth];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      s1_valid  <= 1'b0;
      s1_abs    <= '0;
      s1_sign   <= 1'b0;
      s1_rs     <= '0;
      s1_rm     <= '0;
      s1_effsub <= 1'b0;
      s1_tag    <= '0;
      s1_src    <= '0;
    end else begin
      if (flush_i) s1_valid <= 1'b0;
      else if (s1_free) s1_valid <= accept;
      if (accept) begin
        s1_abs    <= sel_abs;
        s1_sign   <= sel_sign;
        s1_rs     <= sel_rs;
        s1_rm     <= sel_rm;
        s1_effsub <= sel_effsub;
        s1_tag    <= sel_tag;
        s1_src    <= grant_idx;
        rr_q      <= (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_comb begin
    round_up = 1'b0;
    illegal  = 1'b0;
    case (s1_rm)
      RNE:     round_up = s1_rs[1] & (s1_rs[0] | s1_abs[0]);
      RTZ:     round_up = 1'b0;
      RDN:     round_up = (|s1_rs) & s1_sign;
      RUP:     round_up = (|s1_rs) & ~s1_sign;
      RMM:     round_up = s1_rs[1];
      ROD:     round_up = ~s1_abs[0] & (|s1_rs);
      default: illegal  = 1'b1;
    endcase
  end

  // Carry out of the mantissa into the exponent field is the intended
  // behaviour of the increment; all-ones wrapping to zero is not trapped.
  assign abs_rnd    = s1_abs + {{(AbsWidth-1){1'b0}}, round_up};
  assign exact_zero = (s1_abs == '0) & (s1_rs == 2'b00);
  assign sign_res   = (exact_zero & s1_effsub) ? (s1_rm == RDN) : s1_sign;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid      <= 1'b0;
      out_abs_o     <= '0;
      out_sign_o    <= 1'b0;
      out_zero_o    <= 1'b0;
      out_inexact_o <= 1'b0;
      out_illegal_o <= 1'b0;
      out_src_o     <= '0;
      out_tag_o     <= '0;
    end else begin
      if (flush_i) s2_valid <= 1'b0;
      else if (s2_free) s2_valid <= s1_valid;
      if (s2_load) begin
        out_abs_o     <= abs_rnd;
        out_sign_o    <= sign_res;
        out_zero_o    <= exact_zero;
        out_inexact_o <= |s1_rs;
        out_illegal_o <= illegal;
        out_src_o     <= s1_src;
        out_tag_o     <= s1_tag;
      end
    end
  end

  assign out_valid_o = s2_valid;

endmodule

// File: tb/tb_fpnew_round_arbiter.sv
// Directed bench for fpnew_round_arbiter (4 requesters, 31-bit magnitude).
// Expected results are queued at acceptance and compared at output handshake.
module tb_fpnew_round_arbiter;

  typedef struct packed {
    logic [30:0] abs;
    logic        sign;
    logic        zero;
    logic        inex;
    logic        ill;
    logic [1:0]  src;
    logic [3:0]  tag;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [123:0] req_abs;
  logic [3:0]   req_sign;
  logic [7:0]   req_rs;
  logic [11:0]  req_rm;
  logic [3:0]   req_effsub;
  logic [15:0]  req_tag;
  logic         out_valid;
  logic         out_ready;
  logic [30:0]  out_abs;
  logic         out_sign;
  logic         out_zero;
  logic         out_inexact;
  logic         out_illegal;
  logic [1:0]   out_src;
  logic [3:0]   out_tag;

  logic [30:0]  r_abs [4];
  logic         r_sign[4];
  logic [1:0]   r_rs  [4];
  logic [2:0]   r_rm  [4];
  logic         r_eff [4];
  logic [3:0]   r_tag [4];
  res_t         e_res [4];

  res_t         sb[$];
  logic [3:0]   acc_mask;
  bit           one_shot;
  int           checks;
  int           failures;
  logic [3:0]   tag_ctr;

  always #5 clk = ~clk;

  always_comb begin
    req_abs    = '0;
    req_sign   = '0;
    req_rs     = '0;
    req_rm     = '0;
    req_effsub = '0;
    req_tag    = '0;
    for (int i = 0; i < 4; i++) begin
      req_abs[i*31 +: 31] = r_abs[i];
      req_sign[i]         = r_sign[i];
      req_rs[i*2 +: 2]    = r_rs[i];
      req_rm[i*3 +: 3]    = r_rm[i];
      req_effsub[i]       = r_eff[i];
      req_tag[i*4 +: 4]   = r_tag[i];
    end
  end

  fpnew_round_arbiter #(
    .NumReq(4),
    .AbsWidth(31),
    .TagWidth(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_abs_i(req_abs),
    .req_sign_i(req_sign),
    .req_rs_i(req_rs),
    .req_rm_i(req_rm),
    .req_effsub_i(req_effsub),
    .req_tag_i(req_tag),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_abs_o(out_abs),
    .out_sign_o(out_sign),
    .out_zero_o(out_zero),
    .out_inexact_o(out_inexact),
    .out_illegal_o(out_illegal),
    .out_src_o(out_src),
    .out_tag_o(out_tag)
  );

  function automatic res_t obs();
    return {out_abs, out_sign, out_zero, out_inexact,
            out_illegal, out_src, out_tag};
  endfunction

  task automatic check(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic set_req(input int i, input logic [30:0] a,
                         input logic s, input logic [1:0] rs,
                         input logic [2:0] rm, input logic eff,
                         input logic [3:0] tg, input logic [30:0] ea,
                         input logic es, input logic ez,
                         input logic ei, input logic eil);
    r_abs[i]  = a;
    r_sign[i] = s;
    r_rs[i]   = rs;
    r_rm[i]   = rm;
    r_eff[i]  = eff;
    r_tag[i]  = tg;
    e_res[i]  = '{abs: ea, sign: es, zero: ez, inex: ei,
                  ill: eil, src: 2'(i), tag: tg};
    req_valid[i] = 1'b1;
  endtask

  // Exact value, truncation mode: passes through unchanged.
  task automatic set_plain(input int i, input logic [30:0] a,
                           input logic [3:0] tg);
    set_req(i, a, 1'b0, 2'b00, 3'd1, 1'b0, tg,
            a, 1'b0, (a == 31'd0), 1'b0, 1'b0);
  endtask

  // One clock: sample handshakes just after the low phase starts,
  // then step past the rising edge and return on the next falling edge.
  task automatic tick();
    res_t e;
    #1;
    if (out_valid && out_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("result", 64'(obs()), 64'(e));
      end
    end
    acc_mask = '0;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        sb.push_back(e_res[i]);
        acc_mask[i] = 1'b1;
      end
    end
    if (flush) sb.delete();
    @(posedge clk);
    #1;
    if (one_shot) req_valid = req_valid & ~acc_mask;
    @(negedge clk);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (sb.size() == 0 && !out_valid && req_valid == 4'd0) break;
      tick();
    end
    check("drain_sb", 64'(sb.size()), 64'd0);
    check("drain_reqs", 64'(req_valid), 64'd0);
    check("drain_idle", 64'(out_valid), 64'd0);
  endtask

  task automatic round_case(input logic [30:0] a, input logic s,
                            input logic [1:0] rs, input logic [2:0] rm,
                            input logic eff, input logic [30:0] ea,
                            input logic es, input logic ez,
                            input logic ei, input logic eil);
    bit got;
    tag_ctr = tag_ctr + 4'd1;
    set_req(0, a, s, rs, rm, eff, tag_ctr, ea, es, ez, ei, eil);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      got = acc_mask[0];
    end
    req_valid[0] = 1'b0;
    check("round_accept", 64'(got), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    res_t held;
    bit   have;
    int   n_acc;
    int   m;

    checks    = 0;
    failures  = 0;
    tag_ctr   = 4'd0;
    one_shot  = 1'b1;
    acc_mask  = '0;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      r_abs[i] = '0; r_sign[i] = 1'b0; r_rs[i] = '0;
      r_rm[i] = '0; r_eff[i] = 1'b0; r_tag[i] = '0;
      e_res[i] = '0;
    end

    // Reset state, with every requester asking.
    for (int i = 0; i < 4; i++) set_plain(i, 31'h10 + 31'(i), 4'(i));
    @(negedge clk);
    #1;
    check("reset_out", 64'(obs()), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fairness: all valid, consumer always ready.
    one_shot = 1'b0;
    for (int i = 0; i < 4; i++)
      set_plain(i, 31'h100 * 31'(i + 1) + 31'(i), 4'(i + 8));
    m = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("fair_ready", 64'(req_ready), 64'(4'b0001 << m));
      tick();
      m = (m + 1) % 4;
    end
    req_valid = '0;
    one_shot  = 1'b1;
    drain();

    // Rounding modes through requester 0 (rr pointer is back at 0).
    //         abs         s  rs     rm  eff exp_abs    s  z  i  il
    round_case(31'h1,      0, 2'b10, 0,  0,  31'h2,     0, 0, 1, 0);
    round_case(31'h2,      0, 2'b10, 0,  0,  31'h2,     0, 0, 1, 0);
    round_case(31'h3,      0, 2'b10, 0,  0,  31'h4,     0, 0, 1, 0);
    round_case(31'h1,      1, 2'b01, 2,  0,  31'h2,     1, 0, 1, 0);
    round_case(31'h1,      1, 2'b01, 3,  0,  31'h1,     1, 0, 1, 0);
    round_case(31'h1,      0, 2'b01, 2,  0,  31'h1,     0, 0, 1, 0);
    round_case(31'h2,      0, 2'b01, 5,  0,  31'h3,     0, 0, 1, 0);
    round_case(31'h3,      0, 2'b01, 5,  0,  31'h3,     0, 0, 1, 0);
    round_case(31'h1,      0, 2'b11, 7,  0,  31'h1,     0, 0, 1, 1);
    round_case(31'h6,      1, 2'b10, 6,  0,  31'h6,     1, 0, 1, 1);
    round_case(31'h5,      0, 2'b11, 1,  0,  31'h5,     0, 0, 1, 0);
    round_case(31'h7FFFFF, 0, 2'b10, 4,  0,  31'h800000,0, 0, 1, 0);
    round_case(31'h0,      0, 2'b00, 2,  1,  31'h0,     1, 1, 0, 0);
    round_case(31'h0,      0, 2'b00, 0,  1,  31'h0,     0, 1, 0, 0);
    round_case(31'h0,      0, 2'b00, 2,  0,  31'h0,     0, 1, 0, 0);
    round_case(31'h0,      0, 2'b01, 2,  1,  31'h0,     0, 0, 1, 0);
    drain();

    // Backpressure: three offered while the consumer stalls.
    out_ready = 1'b0;
    one_shot  = 1'b1;
    set_plain(0, 31'h111, 4'h1);
    set_plain(1, 31'h222, 4'h2);
    set_plain(2, 31'h333, 4'h3);
    n_acc = 0;
    have  = 1'b0;
    held  = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_acc += $countones(acc_mask);
      if (out_valid) begin
        if (!have) begin
          held = obs();
          have = 1'b1;
        end else begin
          check("bp_stable", 64'(obs()), 64'(held));
        end
      end
    end
    check("bp_accepted", 64'(n_acc), 64'd2);
    check("bp_out_held", 64'(have), 64'd1);
    #1;
    check("bp_ready", 64'(req_ready), 64'd0);
    drain();

    // Flush with both stages full (requester 2 fills them, rr ends at 3).
    out_ready = 1'b0;
    one_shot  = 1'b0;
    set_plain(2, 31'hAAA, 4'h4);
    tick();
    tick();
    tick();
    set_plain(0, 31'hBBB, 4'h5);
    set_plain(3, 31'hCCC, 4'h6);
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_rr_kept", 64'(req_ready), 64'(4'b1000));
    one_shot = 1'b1;
    drain();

    // Reset mid-stream with both stages full.
    out_ready = 1'b0;
    one_shot  = 1'b0;
    set_plain(1, 31'hDDD, 4'h7);
    tick();
    tick();
    tick();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_out", 64'(obs()), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd0);
    sb.delete();
    req_valid = '0;
    @(negedge clk);
    rst      = 1'b0;
    one_shot = 1'b1;
    for (int i = 0; i < 4; i++)
      set_plain(i, 31'h4000 + 31'(i), 4'(i + 12));
    out_ready = 1'b1;
    #1;
    check("rst_first_grant", 64'(req_ready), 64'(4'b0001));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
